cmd_draw_line: RTL and testbench
================================

// Module: cmd_draw_line
// PURPOSE
// Line rasteriser for the draw-line command; one Bresenham pixel per CLK into VRAM port B.
// Downstream of cmd_decoder/packet_reader: coords and colour come from the decoded packet,
// start pulse from the decoder. Writes the back buffer selected by swap_buffer's side.
// BUSY feeds the status byte. Shares port B with cmd_clear through a top-level mux.
// PARAMETERS
// FB_W       256    framebuffer width (pixels); row stride in bytes
// FB_H       192    framebuffer height (pixels)
// ADDR_W     18     VRAM port-B address width
// BUF_BYTES  49152  byte offset of buffer 1 (side=1); buffer 0 is at 0
// PORTS
// CLK          in   1       system clock
// rst_n        in   1       asynchronous reset, active low
// line_req     in   1       1-cycle start pulse; sampled only in IDLE
// x0,y0,x1,y1  in   8 each  endpoints, unsigned; sampled with line_req
// color        in   8       pixel value; sampled with line_req
// side         in   1       front-buffer flag; back buffer = ~side; sampled with line_req
// vram_addr_b  out  ADDR_W  write address
// vram_data_b  out  8       write data (latched color)
// vram_we_b    out  1       write enable, one pixel per asserted cycle
// BUSY         out  1       high from cycle after line_req until done
// done         out  1       1-cycle pulse when line completes
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; vram_addr_b=0, vram_data_b=0, vram_we_b=0, BUSY=0, done=0.
//   Reset mid-line aborts immediately; no further writes.
// - States: IDLE -> SETUP -> PLOT -> DONE -> IDLE.
// - IDLE: on line_req latch coords, color, base = side ? 0 : BUF_BYTES; go to SETUP; BUSY=1 next cycle.
//   line_req while not IDLE is ignored (no queueing).
// - SETUP (1 cycle): dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+-1, err=dx+dy; 10-bit signed math.
// - PLOT: each cycle drive pixel (x,y): addr = base + y*FB_W + x
//   (FB_W=256 -> base + {y,x}); we_b=1.
//   Step: e2=2*err; if e2>=dy {err+=dy; x+=sx}; if e2<=dx {err+=dx; y+=sy}.
//   Leave PLOT after the cycle that writes (x1,y1); exactly max(|dx|,|dy|)+1 write cycles.
// - DONE (1 cycle): we_b=0, done=1, BUSY=0 in that cycle; return to IDLE.
// - Latency: req at T -> first write at T+2 -> done at T+2+N (N = pixel count).
// - x0==x1 && y0==y1: single write, then DONE.
// - Any octant, including reversed endpoints; drawn pixel set independent of direction.
// - vram_we_b low in IDLE/SETUP/DONE; addr/data hold their last values when we_b=0.
// - side toggling mid-line has no effect (base latched at start).
// CONFIGURATION
// DRAW_LINE_CLIP_EN defined:
//   pixels with y>=FB_H get we_b=0 but still take their PLOT cycle, so timing is unchanged.
// Not defined:
//   no clip logic; every PLOT cycle writes. The sender must keep y < FB_H.
// TESTING
// 1 (0,0)->(3,0), color 55h, side 1, req at T:
//   we_b T+2..T+5, addr 0,1,2,3, data 55h; done at T+6; BUSY T+1..T+5.
// 2 (10,10)->(7,13), side 0:
//   addr 51722, 51977, 52232, 52487; then done.
// 3 (5,5)->(5,5): exactly one write at addr base+1285; done the next cycle.
// 4 (0,0)->(2,5), steep:
//   6 writes; y strictly increments each write; x path 0,0,1,1,2,2; last pixel (2,5).
// 5 CLIP_EN, (0,190)->(0,193):
//   writes only y=190,191; 4 PLOT cycles; done at T+6. Without CLIP_EN: 4 writes.
// 6 Second line_req during PLOT: ignored.
//   rst_n low mid-PLOT: we_b=0 and BUSY=0 at once; next req runs normally.

Source files
------------

// File: rtl/cmd_draw_line.sv
// Bresenham line rasteriser: one pixel per clock into VRAM port B.
// Optional macro DRAW_LINE_CLIP_EN suppresses writes for rows y >= FB_H.
module cmd_draw_line #(
  parameter int FB_W      = 256,
  parameter int FB_H      = 192,
  parameter int ADDR_W    = 18,
  parameter int BUF_BYTES = 49152
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              line_req,
  input  logic [7:0]        x0,
  input  logic [7:0]        y0,
  input  logic [7:0]        x1,
  input  logic [7:0]        y1,
  input  logic [7:0]        color,
  input  logic              side,
  output logic [ADDR_W-1:0] vram_addr_b,
  output logic [7:0]        vram_data_b,
  output logic              vram_we_b,
  output logic              BUSY,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_PLOT,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [7:0]          x_q, y_q, xe_q, ye_q, col_q;
  logic [ADDR_W-1:0]   base_q, addr_q;
  logic [7:0]          data_q;
  logic                we_q, busy_q, done_q;
  logic signed [9:0]   dx_q, dy_q, err_q;
  logic                sx_q, sy_q;

  logic [9:0]          adx, ady;
  logic signed [10:0]  e2;
  logic                stepx, stepy, last;
  logic [7:0]          x_d, y_d;
  logic signed [9:0]   err_d;
  logic                vis0, vis1;

  function automatic logic [ADDR_W-1:0] pix(
    input logic [ADDR_W-1:0] base,
    input logic [7:0]        px,
    input logic [7:0]        py
  );
    return base + ADDR_W'(py) * ADDR_W'(FB_W) + ADDR_W'(px);
  endfunction

  always_comb begin
    adx = (xe_q >= x_q) ? {2'b0, xe_q - x_q} : {2'b0, x_q - xe_q};
    ady = (ye_q >= y_q) ? {2'b0, ye_q - y_q} : {2'b0, y_q - ye_q};
    // e2 needs one extra bit: |err| can exceed 255 mid-line
    e2    = {err_q, 1'b0};
    stepx = e2 >= $signed({dy_q[9], dy_q});
    stepy = e2 <= $signed({dx_q[9], dx_q});
    err_d = err_q;
    if (stepx) err_d = err_d + dy_q;
    if (stepy) err_d = err_d + dx_q;
    x_d = x_q;
    y_d = y_q;
    if (stepx) x_d = sx_q ? x_q - 8'd1 : x_q + 8'd1;
    if (stepy) y_d = sy_q ? y_q - 8'd1 : y_q + 8'd1;
    last = (x_q == xe_q) && (y_q == ye_q);
  end

`ifdef DRAW_LINE_CLIP_EN
  assign vis0 = 32'(y_q) < FB_H;
  assign vis1 = 32'(y_d) < FB_H;
`else
  assign vis0 = 1'b1;
  assign vis1 = 1'b1;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      col_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          we_q   <= 1'b0;
          done_q <= 1'b0;
          if (line_req) begin
            x_q     <= x0;
            y_q     <= y0;
            xe_q    <= x1;
            ye_q    <= y1;
            col_q   <= color;
            base_q  <= side ? '0 : ADDR_W'(BUF_BYTES);
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          dx_q  <= $signed(adx);
          dy_q  <= $signed(10'd0 - ady);
          err_q <= $signed(adx - ady);
          sx_q  <= xe_q < x_q;
          sy_q  <= ye_q < y_q;
          we_q  <= vis0;
          if (vis0) begin
            addr_q <= pix(base_q, x_q, y_q);
            data_q <= col_q;
          end
          state_q <= S_PLOT;
        end
        S_PLOT: begin
          if (last) begin
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            err_q <= err_d;
            we_q  <= vis1;
            if (vis1) begin
              addr_q <= pix(base_q, x_d, y_d);
              data_q <= col_q;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vram_addr_b = addr_q;
  assign vram_data_b = data_q;
  assign vram_we_b   = we_q;
  assign BUSY        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_cmd_draw_line.sv
// Scoreboard bench for cmd_draw_line: integer reference model feeds
// expected writes/done cycles; a negedge monitor pops and compares.
module tb_cmd_draw_line;

`ifdef DRAW_LINE_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic        CLK;
  logic        rst_n;
  logic        line_req;
  logic [7:0]  x0, y0, x1, y1, color;
  logic        side;
  logic [17:0] vram_addr_b;
  logic [7:0]  vram_data_b;
  logic        vram_we_b;
  logic        BUSY;
  logic        done;

  cmd_draw_line dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .line_req    (line_req),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .color       (color),
    .side        (side),
    .vram_addr_b (vram_addr_b),
    .vram_data_b (vram_data_b),
    .vram_we_b   (vram_we_b),
    .BUSY        (BUSY),
    .done        (done)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  cyc = 0;
  int  bs = -1;
  int  be = -2;
  int  n_vec = 0;
  int  n_err = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference: spec's Bresenham rule in plain integers
  task automatic model(input int ax0, input int ay0, input int ax1,
                       input int ay1, input int c, input int s,
                       input int t);
    int x, y, dx, dy, sx, sy, err, e2, n, base;
    x    = ax0;
    y    = ay0;
    dx   = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy   = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx   = (ax0 < ax1) ? 1 : -1;
    sy   = (ay0 < ay1) ? 1 : -1;
    err  = dx + dy;
    base = s ? 0 : 49152;
    n    = 0;
    forever begin
      if (!CLIP || y < 192)
        wq.push_back('{base + y * 256 + x, c, t + 2 + n});
      n++;
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    dq.push_back(t + 2 + n);
    bs = t + 1;
    be = t + 1 + n;
  endtask

  always @(negedge CLK) begin
    if (rst_n) begin
      if (vram_we_b) begin
        if (wq.size() == 0) begin
          chk("unexpected_we", 1, 0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", int'(vram_addr_b), w.addr);
          chk("wr_data", int'(vram_data_b), w.data);
          chk("wr_cycle", cyc, w.cyc);
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_cycle", cyc, dq.pop_front());
      end
      chk("busy", int'(BUSY), (cyc >= bs && cyc <= be) ? 1 : 0);
    end
  end

  task automatic issue(input int ax0, input int ay0, input int ax1,
                       input int ay1, input int c, input int s);
    @(negedge CLK);
    x0 = 8'(ax0); y0 = 8'(ay0); x1 = 8'(ax1); y1 = 8'(ay1);
    color = 8'(c); side = s[0]; line_req = 1'b1;
    model(ax0, ay0, ax1, ay1, c, s, cyc);
    @(negedge CLK);
    line_req = 1'b0;
    side = ~side;
    x0 = 8'($urandom); y1 = 8'($urandom); color = 8'($urandom);
  endtask

  task automatic finish_line();
    int k;
    k = 0;
    while (dq.size() != 0 && k < 1100) begin
      @(negedge CLK);
      k++;
    end
    chk("done_timeout", dq.size(), 0);
    chk("writes_left", wq.size(), 0);
    @(negedge CLK);
  endtask

  task automatic line(input int ax0, input int ay0, input int ax1,
                      input int ay1, input int c, input int s);
    issue(ax0, ay0, ax1, ay1, c, s);
    finish_line();
  endtask

  initial begin
    rst_n = 1'b0; line_req = 1'b0; side = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
    repeat (3) @(negedge CLK);
    chk("rst_addr", int'(vram_addr_b), 0);
    chk("rst_data", int'(vram_data_b), 0);
    chk("rst_we", int'(vram_we_b), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge CLK);

    line(0, 0, 3, 0, 8'h55, 1);
    line(10, 10, 7, 13, 8'hA3, 0);
    line(5, 5, 5, 5, 8'h11, 0);
    line(0, 0, 2, 5, 8'h7E, 1);
    line(0, 190, 0, 193, 8'h42, 1);
    line(255, 191, 0, 0, 8'hFF, 0);

    // Second request mid-PLOT must be ignored
    issue(0, 0, 40, 7, 8'h21, 1);
    repeat (5) @(negedge CLK);
    x0 = 8'd100; y0 = 8'd100; x1 = 8'd0; y1 = 8'd0;
    side = 1'b0; line_req = 1'b1;
    @(negedge CLK);
    line_req = 1'b0;
    finish_line();

    // Reset mid-PLOT aborts at once
    issue(0, 0, 100, 20, 8'h33, 0);
    repeat (8) @(negedge CLK);
    rst_n = 1'b0;
    #1;
    chk("abort_we", int'(vram_we_b), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(done), 0);
    wq.delete();
    dq.delete();
    bs = -1;
    be = -2;
    repeat (2) @(negedge CLK);
    chk("abort_we_hold", int'(vram_we_b), 0);
    rst_n = 1'b1;
    @(negedge CLK);
    line(3, 4, 9, 1, 8'h5A, 1);

    for (int i = 0; i < 40; i++) begin
      line($urandom_range(0, 255), $urandom_range(0, 191),
           $urandom_range(0, 255), $urandom_range(0, 191),
           $urandom_range(0, 255), $urandom_range(0, 1));
    end
    for (int i = 0; i < 10; i++) begin
      int bx, by;
      bx = $urandom_range(0, 250);
      by = $urandom_range(0, 185);
      line(bx, by, bx + $urandom_range(0, 5), by + $urandom_range(0, 5),
           $urandom_range(0, 255), $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
